// File: rtl/stopwatch_pkg.sv
// Shared encodings and default timing for the stopwatch front-end controller.
// States, commands and the key arbitration rule live here so every file agrees on them.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;
    localparam logic [1:0] ST_STEP = 2'b11;

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_CLR   = 3'd1;
    localparam logic [2:0] CMD_STOP  = 3'd2;
    localparam logic [2:0] CMD_START = 3'd3;
    localparam logic [2:0] CMD_INC   = 3'd4;

    localparam int DEF_DEB_MS  = 20;
    localparam int DEF_REP_DLY = 500;
    localparam int DEF_REP_PER = 100;
    localparam int DEF_CW      = 10;

    // press bits are {clr, stop, start, inc}; losers in the same cycle are dropped
    function automatic logic [2:0] arbitrate(input logic [3:0] press);
        if (press[3])      return CMD_CLR;
        else if (press[2]) return CMD_STOP;
        else if (press[1]) return CMD_START;
        else if (press[0]) return CMD_INC;
        else               return CMD_NONE;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter-control outputs of the stopwatch front end.
// The controller is the slave; whatever drives the keys is the master.
interface stopwatch_ctrl_if;

    logic       key_start;
    logic       key_stop;
    logic       key_inc;
    logic       key_clr;
    logic       time_en;
    logic       step_pulse;
    logic       clr_pulse;
    logic [1:0] state;

    modport master (
        output key_start, key_stop, key_inc, key_clr,
        input  time_en, step_pulse, clr_pulse, state
    );

    modport slave (
        input  key_start, key_stop, key_inc, key_clr,
        output time_en, step_pulse, clr_pulse, state
    );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw push-button.
// key_press pulses for one cycle on each debounced rising edge; releases are silent.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEB_MS = DEF_DEB_MS,
    parameter int CW     = DEF_CW
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_lvl,
    output logic key_press
);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_MS - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // any sample agreeing with the current level restarts the stability count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync      <= 2'b00;
            cnt       <= '0;
            key_lvl   <= 1'b0;
            key_press <= 1'b0;
        end else begin
            sync      <= {sync[0], key_raw};
            key_press <= 1'b0;
            if (sync[1] != key_lvl) begin
                if (cnt == DEB_LAST) begin
                    key_lvl   <= sync[1];
                    key_press <= sync[1];
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: debounced keys, priority arbitration, run/hold FSM and
// inc auto-repeat, producing registered time_en / step_pulse / clr_pulse.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEB_MS  = DEF_DEB_MS,
    parameter int REP_DLY = DEF_REP_DLY,
    parameter int REP_PER = DEF_REP_PER,
    parameter int CW      = DEF_CW
) (
    input logic             clk,
    input logic             rst,
    stopwatch_ctrl_if.slave sw
);

    if (DEB_MS < 2 || REP_DLY < 2 || REP_PER < 2) begin : g_bad_timing
        $error("stopwatch_ctrl: DEB_MS, REP_DLY and REP_PER must all be at least 2");
    end
    if (DEB_MS >= (1 << CW) || REP_DLY >= (1 << CW) || REP_PER >= (1 << CW)) begin : g_bad_width
        $error("stopwatch_ctrl: CW too narrow for the timing parameters");
    end

    // The first repeat is REP_DLY after the STEP pulse, which already used one cycle before HOLD.
    localparam logic [CW-1:0] REP_FIRST_AT = CW'(REP_DLY - 2);
    localparam logic [CW-1:0] REP_NEXT_AT  = CW'(REP_PER - 1);

    logic [3:0]    key_raw;
    logic [3:0]    key_lvl;
    logic [3:0]    key_press;
    logic          inc_lvl;
    logic          unused_lvl;
    logic [2:0]    cmd;
    logic [1:0]    state_q;
    logic [1:0]    next_state;
    logic          clr_fire;
    logic          hold_stay;
    logic          rep_fire;
    logic          rep_en;
    logic          rep_first;
    logic [CW-1:0] rep_cnt;
    logic          time_en_q;
    logic          step_q;
    logic          clr_q;

    assign key_raw = {sw.key_clr, sw.key_stop, sw.key_start, sw.key_inc};

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEB_MS (DEB_MS),
            .CW     (CW)
        ) u_deb (
            .clk       (clk),
            .rst       (rst),
            .key_raw   (key_raw[k]),
            .key_lvl   (key_lvl[k]),
            .key_press (key_press[k])
        );
    end

    assign inc_lvl    = key_lvl[0];
    assign unused_lvl = ^key_lvl[3:1];
    assign cmd        = arbitrate(key_press);

    // clr is only honoured once the watch is stopped
    always_comb begin
        next_state = state_q;
        clr_fire   = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (cmd == CMD_CLR) begin
                    next_state = ST_IDLE;
                    clr_fire   = 1'b1;
                end else if (cmd == CMD_START) begin
                    next_state = ST_RUN;
                end else if (cmd == CMD_INC) begin
                    next_state = ST_STEP;
                end
            end
            ST_RUN:  if (cmd == CMD_STOP) next_state = ST_HOLD;
            ST_STEP: next_state = ST_HOLD;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_stay = (state_q == ST_HOLD) && (next_state == ST_HOLD);
        rep_fire  = hold_stay && rep_en && inc_lvl &&
                    (rep_cnt == (rep_first ? REP_FIRST_AT : REP_NEXT_AT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            time_en_q <= 1'b0;
            step_q    <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= next_state;
            time_en_q <= (next_state == ST_RUN);
            step_q    <= (next_state == ST_STEP) || rep_fire;
            clr_q     <= clr_fire;
        end
    end

    // Repeat is armed only via STEP, so HOLD entered from RUN never repeats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_en    <= 1'b0;
            rep_first <= 1'b0;
            rep_cnt   <= '0;
        end else if (state_q == ST_STEP) begin
            rep_en    <= 1'b1;
            rep_first <= 1'b1;
            rep_cnt   <= '0;
        end else if (hold_stay && rep_en && inc_lvl) begin
            if (rep_fire) begin
                rep_first <= 1'b0;
                rep_cnt   <= '0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end else begin
            rep_en    <= 1'b0;
            rep_first <= 1'b0;
            rep_cnt   <= '0;
        end
    end

    assign sw.time_en    = time_en_q;
    assign sw.step_pulse = step_q;
    assign sw.clr_pulse  = clr_q;
    assign sw.state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed plus random stimulus against a cycle-level behavioural model; a queue
// scoreboard decouples the model (posedge) from the output monitor (negedge).
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int DEB_MS  = 4;
    localparam int REP_DLY = 10;
    localparam int REP_PER = 3;
    localparam int CW      = 10;

    localparam logic [3:0] K_INC   = 4'b0001;
    localparam logic [3:0] K_START = 4'b0010;
    localparam logic [3:0] K_STOP  = 4'b0100;
    localparam logic [3:0] K_CLR   = 4'b1000;

    typedef struct packed {
        logic       time_en;
        logic       step_pulse;
        logic       clr_pulse;
        logic [1:0] state;
    } out_t;

    typedef enum int {M_IDLE, M_RUN, M_HOLD, M_STEP} mode_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] keys = 4'b0000;
    out_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    stopwatch_ctrl_if sw_if ();

    assign sw_if.key_inc   = keys[0];
    assign sw_if.key_start = keys[1];
    assign sw_if.key_stop  = keys[2];
    assign sw_if.key_clr   = keys[3];

    stopwatch_ctrl #(
        .DEB_MS  (DEB_MS),
        .REP_DLY (REP_DLY),
        .REP_PER (REP_PER),
        .CW      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw_if)
    );

    always #5 clk = ~clk;

    // reference model state: raw sample history, stability run lengths, mode and repeat timer
    mode_t      m_mode;
    bit   [3:0] m_lvl, m_r1, m_r2, m_press, m_new_press;
    int         m_run[4];
    bit         m_armed;
    int         m_t;
    mode_t      m_nxt;
    bit         m_clr, m_fire;
    bit         c_clr, c_stop, c_start, c_inc;
    out_t       m_exp;

    function automatic logic [1:0] mode_code(input mode_t m);
        case (m)
            M_RUN:   return 2'b01;
            M_HOLD:  return 2'b10;
            M_STEP:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_mode  = M_IDLE;
            m_lvl   = '0;
            m_r1    = '0;
            m_r2    = '0;
            m_press = '0;
            m_armed = 1'b0;
            m_t     = 0;
            for (int k = 0; k < 4; k++) m_run[k] = 0;
        end else begin
            c_clr   = m_press[3];
            c_stop  = !m_press[3] && m_press[2];
            c_start = !m_press[3] && !m_press[2] && m_press[1];
            c_inc   = (m_press == K_INC);
            m_nxt   = m_mode;
            m_clr   = 1'b0;
            m_fire  = 1'b0;
            case (m_mode)
                M_IDLE, M_HOLD: begin
                    if (c_clr) begin
                        m_nxt = M_IDLE;
                        m_clr = 1'b1;
                    end else if (c_start) m_nxt = M_RUN;
                    else if (c_inc) m_nxt = M_STEP;
                end
                M_RUN:  if (c_stop) m_nxt = M_HOLD;
                M_STEP: m_nxt = M_HOLD;
                default: m_nxt = M_IDLE;
            endcase
            // m_t = cycles elapsed since the STEP pulse while inc stays held in HOLD
            if (m_mode == M_STEP) begin
                m_armed = 1'b1;
                m_t     = 1;
            end else if (m_mode == M_HOLD && m_nxt == M_HOLD && m_armed && m_lvl[0]) begin
                m_t++;
                m_fire = (m_t == REP_DLY) || (m_t > REP_DLY && ((m_t - REP_DLY) % REP_PER) == 0);
            end else begin
                m_armed = 1'b0;
            end
            m_exp.time_en    = (m_nxt == M_RUN);
            m_exp.step_pulse = (m_nxt == M_STEP) || m_fire;
            m_exp.clr_pulse  = m_clr;
            m_exp.state      = mode_code(m_nxt);
            exp_q.push_back(m_exp);
            m_mode = m_nxt;

            m_new_press = '0;
            for (int k = 0; k < 4; k++) begin
                if (m_r2[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB_MS) begin
                        m_lvl[k]       = m_r2[k];
                        m_run[k]       = 0;
                        m_new_press[k] = m_r2[k];
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_press = m_new_press;
            m_r2    = m_r1;
            m_r1    = keys;
        end
    end

    out_t got, want;

    always @(negedge clk) begin
        got = {sw_if.time_en, sw_if.step_pulse, sw_if.clr_pulse, sw_if.state};
        if (!rst) begin
            exp_q.delete();
            n_checks++;
            if (got !== '0) begin
                n_fail++;
                $display("[TB] FAIL reset_hold: got %b, expected 00000", got);
            end
        end else if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL cycle_outputs @%0t: got te=%b sp=%b cp=%b st=%b, expected te=%b sp=%b cp=%b st=%b",
                         $time, got.time_en, got.step_pulse, got.clr_pulse, got.state,
                         want.time_en, want.step_pulse, want.clr_pulse, want.state);
            end
            n_checks++;
            if ((got.step_pulse && got.clr_pulse) || (got.step_pulse && got.time_en)) begin
                n_fail++;
                $display("[TB] FAIL pulse_exclusive @%0t: got te=%b sp=%b cp=%b, expected no overlap",
                         $time, got.time_en, got.step_pulse, got.clr_pulse);
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] k, input int cycles);
        keys = k;
        repeat (cycles) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkOutput(input string name, input logic [1:0] exp_state, input logic exp_te);
        n_checks++;
        if (sw_if.state !== exp_state || sw_if.time_en !== exp_te) begin
            n_fail++;
            $display("[TB] FAIL %s: got state=%b time_en=%b, expected state=%b time_en=%b",
                     name, sw_if.state, sw_if.time_en, exp_state, exp_te);
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({sw_if.time_en, sw_if.step_pulse, sw_if.clr_pulse, sw_if.state} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_async: got te=%b sp=%b cp=%b st=%b, expected all 0",
                     sw_if.time_en, sw_if.step_pulse, sw_if.clr_pulse, sw_if.state);
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] rk;
        int         rn;

        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        checkOutput("after_reset", 2'b00, 1'b0);

        for (int i = 0; i < 6; i++) applyStimulus((i % 2 == 0) ? K_START : 4'b0000, 2);
        applyStimulus(K_START, 6);
        checkOutput("bounce_no_early", 2'b00, 1'b0);
        applyStimulus(K_START, 1);
        checkOutput("bounce_run", 2'b01, 1'b1);
        applyStimulus(4'b0000, 10);

        applyStimulus(K_STOP, 10);  applyStimulus(4'b0000, 8);
        checkOutput("stop_hold", 2'b10, 1'b0);
        applyStimulus(K_START, 10); applyStimulus(4'b0000, 8);
        checkOutput("resume_run", 2'b01, 1'b1);

        applyStimulus(K_CLR, 10);   applyStimulus(4'b0000, 8);
        checkOutput("clr_in_run", 2'b01, 1'b1);
        applyStimulus(K_STOP, 10);  applyStimulus(4'b0000, 8);
        applyStimulus(K_CLR, 10);   applyStimulus(4'b0000, 8);
        checkOutput("clr_in_hold", 2'b00, 1'b0);

        applyStimulus(K_START | K_INC, 10); applyStimulus(4'b0000, 8);
        checkOutput("start_beats_inc", 2'b01, 1'b1);
        applyStimulus(K_STOP, 10);  applyStimulus(4'b0000, 8);
        applyStimulus(K_STOP | K_CLR, 10); applyStimulus(4'b0000, 8);
        checkOutput("clr_beats_stop", 2'b00, 1'b0);

        applyStimulus(K_INC, 40);   applyStimulus(4'b0000, 15);
        checkOutput("autorepeat_hold", 2'b10, 1'b0);

        applyStimulus(K_START, 10);
        checkOutput("run_before_reset", 2'b01, 1'b1);
        doReset();
        applyStimulus(K_START, 8);
        checkOutput("held_key_after_reset", 2'b01, 1'b1);
        applyStimulus(4'b0000, 10);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) doReset();
            if ($urandom_range(0, 1) == 1) rk = 4'(1 << $urandom_range(0, 3));
            else if ($urandom_range(0, 3) == 0) rk = 4'($urandom_range(0, 15));
            else rk = 4'b0000;
            rn = $urandom_range(1, 14);
            if ($urandom_range(0, 9) == 0) rn = $urandom_range(15, 40);
            applyStimulus(rk, rn);
        end

        applyStimulus(4'b0000, 20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Front-end controller for the stopwatch time counter, running on the 1000 Hz divided clock. It conditions the four raw push-buttons (start, stop, inc, clr), turns them into single-cycle commands, and arbitrates simultaneous presses. A run/hold state machine then sequences the counter datapath through three outputs: the time_en level, a step_pulse for single increments (with auto-repeat while inc is held), and a clr_pulse.

Parameters:
DEB_MS, 20, number of consecutive clk cycles a synchronised key must be stable before its debounced level changes (>=2)
REP_DLY, 500, cycles from the first step_pulse of a held inc key to the first auto-repeat pulse (>=2)
REP_PER, 100, cycles between subsequent auto-repeat pulses (>=2)
CW, 10, width of the debounce and repeat counters; must hold max(DEB_MS, REP_DLY, REP_PER)

Ports:
clk  input  1  1000 Hz divided clock; the only clock
rst  input  1  asynchronous, active-low reset (rst=0 resets)
key_start  input  1  raw start button, active-high, asynchronous to clk
key_stop  input  1  raw stop button, active-high, asynchronous
key_inc  input  1  raw increment button, active-high, asynchronous
key_clr  input  1  raw clear button, active-high, asynchronous
time_en  output  1  counter count-enable; level, registered
step_pulse  output  1  one-cycle request for counter +1
clr_pulse  output  1  one-cycle request to zero the counter
state  output  2  current FSM state, for status LEDs

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0; state=IDLE; synchroniser flops, debounced levels and all counters are 0.
- Key path, per key: 2-flop synchroniser, then the debouncer. The debounced level flips only after the synchronised input has differed from it for DEB_MS consecutive cycles; any agreeing sample restarts the count. A rising edge of the debounced level produces a one-cycle press. Latency from a clean raw edge to the press is 2+DEB_MS cycles. Releases produce no command.
- A key held through reset release is seen as a new press once DEB_MS has elapsed.
- Arbitration: at most one command per cycle, priority clr > stop > start > inc. Lower-priority presses in the same cycle are dropped, not queued.
- FSM encoding: IDLE=00, RUN=01, HOLD=10, STEP=11.
  - IDLE: start -> RUN. inc -> STEP. clr -> IDLE with clr_pulse. stop ignored.
  - RUN: stop -> HOLD. start, inc and clr ignored (the watch must be stopped before it is cleared).
  - STEP: lasts exactly one cycle with step_pulse=1, then -> HOLD.
  - HOLD: start -> RUN. inc -> STEP. clr -> IDLE with clr_pulse. Auto-repeat is active (see below).
  - Illegal encodings cannot occur. If one does, the default branch -> IDLE.
- Outputs are registered from the next-state/command decode, so each appears one cycle after its press:
  - time_en=1 exactly while state==RUN.
  - clr_pulse is high for one cycle.
  - step_pulse is high for one cycle.
- Auto-repeat, HOLD only:
  - The repeat counter is cleared on entry to HOLD from STEP.
  - While the debounced inc level stays 1, the counter counts. It emits step_pulse when it reaches REP_DLY, then every REP_PER cycles.
  - Auto-repeat pulses do not change state.
  - Debounced inc falling, or any state change, clears the counter and stops repeats.
  - Auto-repeat never runs after HOLD is entered from RUN unless inc is pressed anew.
- step_pulse and clr_pulse are never high in the same cycle. time_en and step_pulse are never high in the same cycle.
- Counter widths: CW bits, saturating is not needed because the counters reset at their terminal values. Parameter legality is checked at elaboration.

Decomposition:
- Shared package stopwatch_pkg:
  - state encodings IDLE/RUN/HOLD/STEP as 2-bit localparams
  - command encoding CMD_NONE/CLR/STOP/START/INC (3 bits)
  - default timing constants
- One sub-module, key_debounce (parameter DEB_MS, CW; ports clk, rst, key_raw, key_lvl, key_press), instantiated four times.
- Arbitration, FSM and auto-repeat stay in stopwatch_ctrl.

Test Plan:
(bench parameters DEB_MS=4, REP_DLY=10, REP_PER=3)
1. Bounce: key_start toggles every 2 cycles for 12 cycles, then held stable. The press occurs exactly 6 cycles after the last toggle; time_en rises 1 cycle later; no earlier pulse.
2. Run/hold/resume: press start -> time_en=1, state=01. Press stop -> time_en=0, state=10. Press start -> time_en=1 again. step_pulse stays 0 throughout.
3. Clear gating: press clr in RUN -> no clr_pulse, state stays 01. Stop, then press clr -> clr_pulse for exactly 1 cycle, state=00.
4. Simultaneous: start and inc raw edges in the same cycle from IDLE -> state RUN, zero step_pulses. Stop and clr together in HOLD -> clr_pulse, state IDLE.
5. Auto-repeat: from IDLE, hold inc for 30 cycles after its press. step_pulse appears at press+1, then at +11, +14, +17, … while inc is held. Releasing inc (after debounce) stops all pulses.
6. Reset mid-operation: assert rst=0 while in RUN with key_start held. All outputs go 0 immediately. After rst=1, the held key yields a press 6 cycles later and time_en returns to 1.
